// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and sizing helpers for the register file
package regfile_pkg;
   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;
   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction
   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction
endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: sweeps every register index to zero after reset or on request
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clear_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(depth_of(ADDR_W) - 1);
   rf_state_t state, state_nx;
   logic [ADDR_W-1:0] idx_nx;
   always_ff @(posedge clk)
      if (!rstn) begin
         state <= CLEAR_ON_RESET ? RF_CLEAR : RF_IDLE;
         clr_idx <= '0;
      end else begin
         state <= state_nx;
         clr_idx <= idx_nx;
      end
   always_comb begin
      state_nx = state == RF_CLEAR ? (clr_idx == LAST ? RF_IDLE : RF_CLEAR) : (clear_req ? RF_CLEAR : RF_IDLE);
      idx_nx = (state == RF_CLEAR && clr_idx != LAST) ? clr_idx + ADDR_W'(1) : '0;
   end
   always_comb begin
      busy = state == RF_CLEAR;
      clr_we = busy;
   end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with write-to-read bypass and sequenced clear
module regfile_param
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter bit BYPASS = 1'b1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
   output logic [NUM_RD*DATA_W-1:0] RdData,
   input  logic [ADDR_W-1:0]        WriteReg,
   input  logic [DATA_W-1:0]        WriteData,
   input  logic                     RegWrite,
   input  logic                     clear_req,
   output logic                     busy,
   input  logic [ADDR_W-1:0]        regNo,
   output logic [DATA_W-1:0]        val
);
   localparam int DEPTH = depth_of(ADDR_W);
   logic [DATA_W-1:0] regs [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   regfile_clear_seq #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_seq (
      .clk(clk),
      .rstn(rstn),
      .clear_req(clear_req),
      .busy(busy),
      .clr_we(clr_we),
      .clr_idx(clr_idx)
   );
   always_ff @(posedge clk)
      if (rstn) begin
         if (clr_we) regs[clr_idx] <= '0;
         else if (RegWrite && WriteReg != '0) regs[WriteReg] <= WriteData;
      end
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = RdAddr[slice_lo(k, ADDR_W) +: ADDR_W];
      assign RdData[slice_lo(k, DATA_W) +: DATA_W] = (busy || a == '0) ? '0 :
                                                      (BYPASS && RegWrite && WriteReg == a) ? WriteData : regs[a];
   end
   assign val = regNo == '0 ? '0 : regs[regNo];
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed vectors and clear/reset sequences across three configurations
module tb_regfile_param;
   logic        clk = 1'b0;
   logic        rstn;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data_a, rd_data_b;
   logic [4:0]  wreg, regno;
   logic [31:0] wdata, val_a, val_b;
   logic        we, clear_req, busy_a, busy_b;
   logic [15:0]  c_rdaddr;
   logic [255:0] c_rddata;
   logic [3:0]   c_wreg, c_regno;
   logic [63:0]  c_wdata, c_val;
   logic         c_we, c_clr, c_busy;
   int total = 0;
   int bad = 0;
   int n;

   always #5 clk = ~clk;

   regfile_param dut_a (
      .clk(clk), .rstn(rstn), .RdAddr(rd_addr), .RdData(rd_data_a), .WriteReg(wreg), .WriteData(wdata),
      .RegWrite(we), .clear_req(clear_req), .busy(busy_a), .regNo(regno), .val(val_a));
   regfile_param #(.BYPASS(1'b0)) dut_b (
      .clk(clk), .rstn(rstn), .RdAddr(rd_addr), .RdData(rd_data_b), .WriteReg(wreg), .WriteData(wdata),
      .RegWrite(we), .clear_req(clear_req), .busy(busy_b), .regNo(regno), .val(val_b));
   regfile_param #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) dut_c (
      .clk(clk), .rstn(rstn), .RdAddr(c_rdaddr), .RdData(c_rddata), .WriteReg(c_wreg), .WriteData(c_wdata),
      .RegWrite(c_we), .clear_req(c_clr), .busy(c_busy), .regNo(c_regno), .val(c_val));

   typedef struct {
      logic we;
      logic [4:0] wr, ra0, ra1, rn;
      logic [31:0] wd, e0, e1, eb0, eb1, ev;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic count_busy(input bit sel, output int cnt);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!(sel ? c_busy : busy_a)) break;
         cnt++;
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [63:0] cval(input int i);
      return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h1111_1111_1111_1111);
   endfunction

   initial begin
      logic [3:0] idx [2][4];
      int na, nc;
      tv[0] = '{1'b1, 5'd5,  5'd5, 5'd31, 5'd5,  32'h12345678, 32'h12345678, 32'h0,        32'h0,        32'h0,        32'h0};
      tv[1] = '{1'b1, 5'd31, 5'd5, 5'd31, 5'd31, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'h0,        32'h0};
      tv[2] = '{1'b1, 5'd0,  5'd5, 5'd31, 5'd31, 32'hAAAA5555, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF};
      tv[3] = '{1'b0, 5'd0,  5'd0, 5'd8,  5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
      tv[4] = '{1'b1, 5'd7,  5'd0, 5'd0,  5'd0,  32'h11110000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0};
      tv[5] = '{1'b1, 5'd7,  5'd7, 5'd5,  5'd7,  32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678, 32'h11110000, 32'h12345678, 32'h11110000};
      tv[6] = '{1'b1, 5'd0,  5'd0, 5'd7,  5'd7,  32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
      tv[7] = '{1'b0, 5'd7,  5'd7, 5'd31, 5'd5,  32'h0,        32'hCAFEF00D, 32'hFFFFFFFF, 32'hCAFEF00D, 32'hFFFFFFFF, 32'h12345678};
      idx[0] = '{4'd3, 4'd15, 4'd0, 4'd9};
      idx[1] = '{4'd1, 4'd14, 4'd7, 4'd8};

      rstn = 1'b0; rd_addr = '0; wreg = '0; wdata = '0; we = 1'b0; clear_req = 1'b0; regno = '0;
      c_rdaddr = '0; c_wreg = '0; c_wdata = '0; c_we = 1'b0; c_clr = 1'b0; c_regno = '0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_busy_a", busy_a, 1);
      chk("rst_busy_c", c_busy, 1);
      chk("rst_rd_a", rd_data_a, 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      we = 1'b1; wreg = 5'd8; wdata = 32'hDEADBEEF; rd_addr = {5'd8, 5'd8};
      na = 0; nc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0 || i == 31) chk("busy_rd_bypass_off", rd_data_a, 0);
         na += int'(busy_a);
         nc += int'(c_busy);
         @(posedge clk); #1;
         we = (i == 30);
      end
      we = 1'b0;
      chk("sweep_len_a", na, 32);
      chk("sweep_len_c", nc, 16);

      for (int i = 0; i < 32; i++) begin
         rd_addr = {5'(i), 5'(i)}; regno = 5'(i);
         @(negedge clk);
         chk("post_rst_rd", rd_data_a, 0);
         chk("post_rst_val", val_a, 0);
         @(posedge clk); #1;
      end

      for (int v = 0; v < 8; v++) begin
         we = tv[v].we; wreg = tv[v].wr; wdata = tv[v].wd; rd_addr = {tv[v].ra1, tv[v].ra0}; regno = tv[v].rn;
         @(negedge clk);
         chk($sformatf("vec%0d_a0", v), rd_data_a[31:0], tv[v].e0);
         chk($sformatf("vec%0d_a1", v), rd_data_a[63:32], tv[v].e1);
         chk($sformatf("vec%0d_b0", v), rd_data_b[31:0], tv[v].eb0);
         chk($sformatf("vec%0d_b1", v), rd_data_b[63:32], tv[v].eb1);
         chk($sformatf("vec%0d_val_a", v), val_a, tv[v].ev);
         chk($sformatf("vec%0d_val_b", v), val_b, tv[v].ev);
         @(posedge clk); #1;
      end
      we = 1'b0;

      for (int i = 0; i < 16; i++) begin
         c_we = 1'b1; c_wreg = 4'(i); c_wdata = cval(i);
         @(posedge clk); #1;
      end
      c_we = 1'b0;
      for (int s = 0; s < 2; s++) begin
         c_rdaddr = {idx[s][3], idx[s][2], idx[s][1], idx[s][0]};
         @(negedge clk);
         for (int p = 0; p < 4; p++)
            chk($sformatf("c_rd%0d_p%0d", s, p), c_rddata[p*64 +: 64], idx[s][p] == 4'd0 ? 64'h0 : cval(int'(idx[s][p])));
         @(posedge clk); #1;
      end
      c_regno = 4'd9;
      @(negedge clk);
      chk("c_val", c_val, cval(9));
      @(posedge clk); #1;
      c_clr = 1'b1;
      @(posedge clk); #1;
      c_clr = 1'b0;
      count_busy(1'b1, n);
      chk("c_clr_len", n, 16);
      c_rdaddr = {4'd9, 4'd0, 4'd15, 4'd3};
      @(negedge clk);
      chk("c_after_clr", c_rddata, 0);
      @(posedge clk); #1;

      for (int i = 1; i < 32; i++) begin
         we = 1'b1; wreg = 5'(i); wdata = 32'(i) * 32'h11;
         @(posedge clk); #1;
      end
      we = 1'b1; wreg = 5'd3; wdata = 32'h77; clear_req = 1'b1; regno = 5'd3; rd_addr = {5'd20, 5'd20};
      @(posedge clk); #1;
      we = 1'b0; clear_req = 1'b0;
      n = 0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         if (!busy_a) break;
         if (j == 0) chk("clr_wr_commit", val_a, 32'h77);
         if (j == 10) begin
            chk("clr_partial", val_a, 32'h154);
            chk("clr_rd_busy", rd_data_a, 0);
         end
         if (j == 25) chk("clr_swept", val_a, 0);
         n++;
         @(posedge clk); #1;
         regno = 5'd20;
         clear_req = (j == 5);
      end
      @(posedge clk); #1;
      clear_req = 1'b0;
      chk("clr_len", n, 32);
      for (int i = 0; i < 32; i++) begin
         rd_addr = {5'(i), 5'(i)}; regno = 5'(i);
         @(negedge clk);
         chk("post_clr_rd", rd_data_a, 0);
         chk("post_clr_val", val_a, 0);
         @(posedge clk); #1;
      end

      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rstn = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;
      count_busy(1'b0, n);
      chk("rst_mid_sweep_len", n, 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
